// File: rtl/stream_add_queue_pkg.sv
// Shared constants for the stream adder queue: saturation mode encodings and default width.
package stream_add_queue_pkg;

    localparam logic SAT_WRAP       = 1'b0;
    localparam logic SAT_CLAMP      = 1'b1;
    localparam int   DATA_W_DEFAULT = 32;

endpackage : stream_add_queue_pkg

// File: rtl/stream_add_queue_if.sv
// Bundles the input stream, output stream, runtime configuration and status signals.
interface stream_add_queue_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              i_stream_val;
    logic              i_stream_rdy;
    logic [DATA_W-1:0] i_stream_data;
    logic [DATA_W-1:0] cfg_addend;
    logic              cfg_sat;
    logic              o_stream_val;
    logic              o_stream_rdy;
    logic [DATA_W-1:0] o_stream_data;
    logic [CNT_W-1:0]  occupancy;
    logic              ovf_sticky;

    modport slave (
        input  i_stream_val, i_stream_data, cfg_addend, cfg_sat, o_stream_rdy,
        output i_stream_rdy, o_stream_val, o_stream_data, occupancy, ovf_sticky
    );

    modport master (
        output i_stream_val, i_stream_data, cfg_addend, cfg_sat, o_stream_rdy,
        input  i_stream_rdy, o_stream_val, o_stream_data, occupancy, ovf_sticky
    );
endinterface : stream_add_queue_if

// File: rtl/stream_add_queue_fifo.sv
// DEPTH-entry val/rdy FIFO with occupancy counter; a full FIFO still accepts a word
// in a cycle where its head is popped.
module stream_add_queue_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_val_i,
    input  logic [DATA_W-1:0]          push_data_i,
    output logic                       push_rdy_o,
    output logic                       pop_val_o,
    input  logic                       pop_rdy_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]  wr_en;
    logic              push;
    logic              pop;

    assign push_rdy_o  = (cnt_q < CNT_W'(DEPTH)) || pop_rdy_i;
    assign pop_val_o   = (cnt_q != '0);
    assign push        = push_val_i && push_rdy_o;
    assign pop         = pop_val_o && pop_rdy_i;
    assign occupancy_o = cnt_q;
    // Head read is combinational so a pushed word is visible the very next cycle.
    assign pop_data_o  = pop_val_o ? mem_q[rd_ptr_q] : '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the output is masked to zero while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= push_data_i;
            end
        end
    end

endmodule : stream_add_queue_fifo

// File: rtl/stream_add_queue.sv
// Stream adder: each accepted word plus a runtime addend (wrap or unsigned saturate)
// is queued in an output FIFO; any carry-out sets a sticky overflow flag.
module stream_add_queue
    import stream_add_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    stream_add_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic              in_rdy;
    logic              out_val;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  occ;
    logic              push;
    logic              ovf_q, ovf_d;

    always_comb begin
        sum    = {1'b0, bus.i_stream_data} + {1'b0, bus.cfg_addend};
        result = sum[DATA_W-1:0];
        if ((bus.cfg_sat == SAT_CLAMP) && sum[DATA_W]) begin
            result = '1;
        end
    end

    assign push  = bus.i_stream_val && in_rdy;
    // Carry-out flags overflow in either mode, even when the stored value is clamped.
    assign ovf_d = ovf_q | (push & sum[DATA_W]);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    stream_add_queue_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_val_i  (bus.i_stream_val),
        .push_data_i (result),
        .push_rdy_o  (in_rdy),
        .pop_val_o   (out_val),
        .pop_rdy_i   (bus.o_stream_rdy),
        .pop_data_o  (out_data),
        .occupancy_o (occ)
    );

    assign bus.i_stream_rdy  = in_rdy;
    assign bus.o_stream_val  = out_val;
    assign bus.o_stream_data = out_data;
    assign bus.occupancy     = occ;
    assign bus.ovf_sticky    = ovf_q;

endmodule : stream_add_queue
